// File: rtl/inv_sbox_word_pkg.sv
// Shared constants, FSM state type and AES S-box table functions for the inv_sbox_word slice.
// With INV_SBOX_FWD_MODE_EN the ROM doubles to hold the forward table above the inverse one.
package sbox_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;

`ifdef INV_SBOX_FWD_MODE_EN
    localparam int ROM_ADDR_W = 9;
`else
    localparam int ROM_ADDR_W = 8;
`endif
    localparam int ROM_DEPTH  = 32'd1 << ROM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FLUSH  = 2'd2,
        OUT    = 2'd3
    } state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) begin
                p = p ^ x;
            end
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < n; i++) begin
            v = {v[6:0], v[7]};
        end
        return v;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    // Inverse table occupies addresses 0..255, forward table 256..511.
    function automatic logic [7:0] rom_entry(input int idx);
        logic [31:0] u;
        u = idx;
        if (u[8]) begin
            return fwd_sbox(u[7:0]);
        end else begin
            return inv_sbox(u[7:0]);
        end
    endfunction

endpackage

// File: rtl/inv_sbox_word_rom.sv
// Constant S-box ROM with a registered read port; q clears on reset, the array has no reset.
// Address is 9 bits ({mode, byte}) when INV_SBOX_FWD_MODE_EN is defined, otherwise 8 bits.
module inv_sbox_rom
    import sbox_pkg::*;
#(
    parameter string ROM_STYLE = "block"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [BYTE_W-1:0]     q
);

    if (ROM_STYLE == "distributed") begin : g_dist
        (* rom_style = "distributed" *) logic [BYTE_W-1:0] mem [ROM_DEPTH];

        for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_init
            assign mem[i] = rom_entry(i);
        end

        // Registered table read
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q <= 8'h00;
            end else begin
                q <= mem[addr];
            end
        end
    end else begin : g_block
        (* rom_style = "block" *) logic [BYTE_W-1:0] mem [ROM_DEPTH];

        for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_init
            assign mem[i] = rom_entry(i);
        end

        // Registered table read
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q <= 8'h00;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/inv_sbox_word.sv
// Byte-serial AES InvSubWord engine: one byte per cycle through a registered S-box ROM.
// Optional INV_SBOX_FWD_MODE_EN adds fwd_mode, selecting the forward table per accepted word.
module inv_sbox_word
    import sbox_pkg::*;
#(
    parameter string ROM_STYLE = "block"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef INV_SBOX_FWD_MODE_EN
    input  logic              fwd_mode,
`endif
    output logic [WORD_W-1:0] dout,
    output logic              busy
);

    state_e                  state_r;
    state_e                  state_s;
    logic [1:0]              cnt_r;
    logic [1:0]              cnt_m1_s;
    logic [WORD_W-1:0]       word_r;
    logic [WORD_W-1:0]       dout_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic                    accept_s;
    logic [BYTE_W-1:0]       byte_s;
    logic [ROM_ADDR_W-1:0]   rom_addr_s;
    logic [BYTE_W-1:0]       rom_q_s;
`ifdef INV_SBOX_FWD_MODE_EN
    logic                    mode_r;
`endif

    assign accept_s  = (state_r == IDLE) && in_valid;
    assign cnt_m1_s  = cnt_r - 2'd1;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign dout      = dout_r;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (cnt_r == 2'd3) begin
                    state_s = FLUSH;
                end else begin
                    state_s = LOOKUP;
                end
            end
            FLUSH: begin
                state_s = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // ROM address selects the current byte of the latched word
    always_comb begin
        byte_s = word_r[{cnt_r, 3'b000} +: BYTE_W];
`ifdef INV_SBOX_FWD_MODE_EN
        rom_addr_s = {mode_r, byte_s};
`else
        rom_addr_s = byte_s;
`endif
    end

    inv_sbox_rom #(
        .ROM_STYLE (ROM_STYLE)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (rom_addr_s),
        .q     (rom_q_s)
    );

    // State register; handshake flags are registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == OUT);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Word capture and byte counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r <= 32'h0000_0000;
            cnt_r  <= 2'd0;
`ifdef INV_SBOX_FWD_MODE_EN
            mode_r <= 1'b0;
`endif
        end else if (accept_s) begin
            word_r <= din;
            cnt_r  <= 2'd0;
`ifdef INV_SBOX_FWD_MODE_EN
            mode_r <= fwd_mode;
`endif
        end else if ((state_r == LOOKUP) && (cnt_r != 2'd3)) begin
            cnt_r <= cnt_r + 2'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result assembly: ROM output lags the address by one edge, so byte cnt-1 lands here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r <= 32'h0000_0000;
        end else if ((state_r == LOOKUP) && (cnt_r != 2'd0)) begin
            dout_r[{cnt_m1_s, 3'b000} +: BYTE_W] <= rom_q_s;
        end else if (state_r == FLUSH) begin
            dout_r[3*BYTE_W +: BYTE_W] <= rom_q_s;
        end else begin
            dout_r <= dout_r;
        end
    end

endmodule

// File: tb/tb_inv_sbox_word.sv
// Directed self-checking bench for inv_sbox_word; covers fwd_mode when INV_SBOX_FWD_MODE_EN is set.
module tb_inv_sbox_word;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;
    logic        busy;
`ifdef INV_SBOX_FWD_MODE_EN
    logic        fwd_mode;
`endif

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    int ov_cnt = 0;

    always #5 clk = ~clk;

    inv_sbox_word dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef INV_SBOX_FWD_MODE_EN
        .fwd_mode  (fwd_mode),
`endif
        .dout      (dout),
        .busy      (busy)
    );

    // Count output handshakes and cycles with out_valid high
    always @(posedge clk) begin
        if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a word for one accepting edge; returns at the negedge after acceptance
    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        din      = w;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int x0;
        int o0;
        int stable;

        reset     = 1'b1;
        in_valid  = 1'b0;
        din       = 32'h0;
        out_ready = 1'b1;
`ifdef INV_SBOX_FWD_MODE_EN
        fwd_mode  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dout", dout, 32'h0000_0000);
        check("rst_busy", 32'(busy), 32'd0);

        // Single word with out_ready high
        send_word(32'hED16_7C63);
        check("single_busy", 32'(busy), 32'd1);
        check("single_in_ready", 32'(in_ready), 32'd0);
        wait_out(lat);
        check("single_latency", 32'(lat), 32'd5);
        check("single_dout", dout, 32'h53FF_0100);
        @(negedge clk);
        check("single_ov_drop", 32'(out_valid), 32'd0);
        check("single_in_ready_back", 32'(in_ready), 32'd1);
        check("single_xfers", 32'(xfer_cnt), 32'd1);

        // Backpressure: result held for 10 cycles
        out_ready = 1'b0;
        send_word(32'hED16_7C63);
        wait_out(lat);
        check("bp_latency", 32'(lat), 32'd5);
        stable = 0;
        repeat (10) begin
            if (out_valid === 1'b1 && dout === 32'h53FF_0100 && in_ready === 1'b0) stable++;
            @(negedge clk);
        end
        check("bp_hold_cycles", 32'(stable), 32'd10);
        x0 = xfer_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ov_drop", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("bp_single_xfer", 32'(xfer_cnt - x0), 32'd1);

        // in_valid during LOOKUP is ignored
        x0 = xfer_cnt;
        send_word(32'h0000_0000);
        in_valid = 1'b1;
        din      = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("busy_ign_latency", 32'(lat), 32'd4);
        check("busy_ign_dout", dout, 32'h5252_5252);
        repeat (12) @(negedge clk);
        check("busy_ign_xfers", 32'(xfer_cnt - x0), 32'd1);
        check("busy_ign_idle", 32'(busy), 32'd0);

        // Reset two cycles into an operation
        o0 = ov_cnt;
        send_word(32'h1616_1616);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_dout", dout, 32'h0000_0000);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);
        check("midrst_no_ov", 32'(ov_cnt - o0), 32'd0);
        send_word(32'h6363_6363);
        wait_out(lat);
        check("post_rst_latency", 32'(lat), 32'd5);
        check("post_rst_dout", dout, 32'h0000_0000);
        @(negedge clk);

        // Mixed bytes through the inverse table
        send_word(32'hFF53_0100);
        wait_out(lat);
        check("inv_mixed_dout", dout, 32'h7D50_0952);
        @(negedge clk);

`ifdef INV_SBOX_FWD_MODE_EN
        fwd_mode = 1'b1;
        send_word(32'hFF53_0100);
        fwd_mode = 1'b0;
        wait_out(lat);
        check("fwd_latency", 32'(lat), 32'd5);
        check("fwd_dout", dout, 32'h16ED_7C63);
        @(negedge clk);
        send_word(32'hED16_7C63);
        wait_out(lat);
        check("fwd0_dout", dout, 32'h53FF_0100);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
